// File: rtl/uart_frame_packer_if.sv
// Bus bundle for uart_frame_packer: capture-FIFO read side, UART transmitter handshake and frame status.
// master = packer, slave = FIFO/transmitter environment.
//
// Handshakes: rd_req is a one-cycle strobe issued only while rd_empty is low, and data_in is sampled
// one full cycle after the strobe. tx_req is a one-cycle request with data_out valid. data_out then
// stays stable until the transmitter has raised tx_busy and dropped it again. No new request is made
// before that falling edge.
interface uart_frame_packer_if #(
    parameter int WORD_W = 16
);
    logic              frame_start;
    logic [WORD_W-1:0] data_in;
    logic              rd_empty;
    logic              rd_req;
    logic [7:0]        data_out;
    logic              tx_req;
    logic              tx_busy;
    logic              frame_err;
    logic              busy;
    logic [2:0]        dbg_state;

    modport master (
        input  frame_start, data_in, rd_empty, tx_busy,
        output rd_req, data_out, tx_req, frame_err, busy, dbg_state
    );

    modport slave (
        output frame_start, data_in, rd_empty, tx_busy,
        input  rd_req, data_out, tx_req, frame_err, busy, dbg_state
    );
endinterface

// File: rtl/uart_frame_packer.sv
// Frames capture-FIFO words into a byte stream for the UART: sync bytes, FRAME_WORDS payload words,
// optional trailing two's-complement checksum when FRAME_CSUM_EN is defined.
module uart_frame_packer #(
    parameter int          WORD_W      = 16,
    parameter int          MSB_FIRST   = 1,
    parameter int          SYNC_LEN    = 2,
    parameter logic [31:0] SYNC_PAT    = 32'h0000_FF00,
    parameter int          FRAME_WORDS = 76800,
    parameter int          CNT_W       = 17
) (
    input  logic                SYS_CLK,
    input  logic                RST_N,
    uart_frame_packer_if.master bus
);
    localparam int NBYTES = WORD_W / 8;
    localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_FETCH, S_LATCH, S_SEND, S_ACK, S_DONE
`ifdef FRAME_CSUM_EN
        , S_CSUM
`endif
    } state_t;

    typedef enum logic [1:0] {
        P_SYNC, P_DATA
`ifdef FRAME_CSUM_EN
        , P_CSUM
`endif
    } phase_t;

    state_t            r_state;
    phase_t            r_phase;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [BI_W-1:0]   r_byte_idx;
    logic [1:0]        r_sync_idx;
    logic [WORD_W-1:0] r_word;
    logic              r_start_pend;
    logic              r_rd_req;
    logic              r_tx_req;
    logic [7:0]        r_data_out;
    logic              r_frame_err;
    logic              r_busy;
`ifdef FRAME_CSUM_EN
    logic [7:0]        r_csum;
`endif

    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_last_byte;
    logic [7:0]        w_lat_byte;
    logic [7:0]        w_next_byte;

    // Sync byte k of the frame; the pattern is sent from byte SYNC_LEN-1 down to byte 0.
    function automatic logic [7:0] f_sync_byte(input logic [1:0] k);
        logic [1:0] pos;
        pos         = 2'(SYNC_LEN - 1) - k;
        f_sync_byte = 8'(SYNC_PAT >> {pos, 3'b000});
    endfunction

    function automatic logic [7:0] f_word_byte(input logic [WORD_W-1:0] w, input logic [BI_W-1:0] idx);
        logic [BI_W-1:0] pos;
        pos         = (MSB_FIRST != 0) ? BI_W'(NBYTES - 1) - idx : idx;
        f_word_byte = 8'(w >> {pos, 3'b000});
    endfunction

    assign w_cnt_next  = r_word_cnt + 1'b1;
    assign w_last_byte = (r_byte_idx == BI_W'(NBYTES - 1));
    assign w_lat_byte  = f_word_byte(bus.data_in, '0);
    assign w_next_byte = f_word_byte(r_word, r_byte_idx + 1'b1);

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= S_IDLE;
            r_phase      <= P_SYNC;
            r_word_cnt   <= '0;
            r_byte_idx   <= '0;
            r_sync_idx   <= '0;
            r_word       <= '0;
            r_start_pend <= 1'b0;
            r_rd_req     <= 1'b0;
            r_tx_req     <= 1'b0;
            r_data_out   <= '0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
`ifdef FRAME_CSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_rd_req    <= 1'b0;
            r_tx_req    <= 1'b0;
            r_frame_err <= 1'b0;
            if (bus.frame_start && r_state != S_IDLE) r_start_pend <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    // A frame_start arriving while a pending start is consumed merges into one frame.
                    if (bus.frame_start || r_start_pend) begin
                        r_start_pend <= 1'b0;
                        r_busy       <= 1'b1;
                        r_word_cnt   <= '0;
                        r_byte_idx   <= '0;
                        r_sync_idx   <= '0;
`ifdef FRAME_CSUM_EN
                        r_csum       <= '0;
`endif
                        if (SYNC_LEN > 0) begin
                            r_phase <= P_SYNC;
                            r_state <= S_SYNC;
                        end else begin
                            r_phase <= P_DATA;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_SYNC: begin
                    r_data_out <= f_sync_byte(r_sync_idx);
                    r_tx_req   <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_FETCH: begin
                    if (!bus.rd_empty) begin
                        r_rd_req <= 1'b1;
                        r_state  <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // First LATCH cycle (strobe still high) covers the FIFO read latency.
                    if (!r_rd_req) begin
                        r_word     <= bus.data_in;
                        r_byte_idx <= '0;
                        r_data_out <= w_lat_byte;
                        r_tx_req   <= 1'b1;
`ifdef FRAME_CSUM_EN
                        r_csum     <= r_csum + w_lat_byte;
`endif
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: r_state <= S_ACK;
                S_ACK:  if (bus.tx_busy) r_state <= S_DONE;
                S_DONE: begin
                    if (!bus.tx_busy) begin
                        case (r_phase)
                            P_SYNC: begin
                                if (r_sync_idx == 2'(SYNC_LEN - 1)) begin
                                    r_phase <= P_DATA;
                                    r_state <= S_FETCH;
                                end else begin
                                    r_sync_idx <= r_sync_idx + 2'd1;
                                    r_state    <= S_SYNC;
                                end
                            end
                            P_DATA: begin
                                if (!w_last_byte) begin
                                    r_byte_idx <= r_byte_idx + 1'b1;
                                    r_data_out <= w_next_byte;
                                    r_tx_req   <= 1'b1;
`ifdef FRAME_CSUM_EN
                                    r_csum     <= r_csum + w_next_byte;
`endif
                                    r_state    <= S_SEND;
                                end else begin
                                    r_word_cnt <= w_cnt_next;
                                    if (w_cnt_next == CNT_W'(FRAME_WORDS) || r_start_pend) begin
                                        r_frame_err <= (w_cnt_next != CNT_W'(FRAME_WORDS));
`ifdef FRAME_CSUM_EN
                                        r_phase     <= P_CSUM;
                                        r_state     <= S_CSUM;
`else
                                        r_busy      <= 1'b0;
                                        r_state     <= S_IDLE;
`endif
                                    end else begin
                                        r_state <= S_FETCH;
                                    end
                                end
                            end
`ifdef FRAME_CSUM_EN
                            P_CSUM: begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
`endif
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
`ifdef FRAME_CSUM_EN
                S_CSUM: begin
                    r_data_out <= ~r_csum + 8'd1;
                    r_tx_req   <= 1'b1;
                    r_state    <= S_SEND;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_req    = r_rd_req;
    assign bus.tx_req    = r_tx_req;
    assign bus.data_out  = r_data_out;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: three configurations share one FIFO model and one transmitter model;
// only the selected instance is ever started, so the others stay idle.
module tb_uart_frame_packer;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;

    logic        frame_start = 1'b0;
    logic        rd_empty    = 1'b1;
    logic        tx_busy     = 1'b0;
    logic [63:0] data_in     = '0;
    logic [63:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  csum_acc    = '0;
    int          tx_cnt = 0, rd_cnt = 0, ferr_cnt = 0;
    int          tx_lat = 1, tx_len = 3;
    bit          tx_auto = 1'b0;

    uart_frame_packer_if #(.WORD_W(16)) if_a ();
    uart_frame_packer_if #(.WORD_W(16)) if_b ();
    uart_frame_packer_if #(.WORD_W(32)) if_c ();

    assign if_a.frame_start = frame_start && (sel == 0);
    assign if_b.frame_start = frame_start && (sel == 1);
    assign if_c.frame_start = frame_start && (sel == 2);
    assign if_a.data_in = data_in[15:0];
    assign if_b.data_in = data_in[15:0];
    assign if_c.data_in = data_in[31:0];
    assign if_a.rd_empty = rd_empty;
    assign if_b.rd_empty = rd_empty;
    assign if_c.rd_empty = rd_empty;
    assign if_a.tx_busy = tx_busy;
    assign if_b.tx_busy = tx_busy;
    assign if_c.tx_busy = tx_busy;

    uart_frame_packer #(.FRAME_WORDS(2), .CNT_W(2)) dut_a (
        .SYS_CLK(clk), .RST_N(rst_n), .bus(if_a.master));
    uart_frame_packer #(.FRAME_WORDS(8), .CNT_W(4)) dut_b (
        .SYS_CLK(clk), .RST_N(rst_n), .bus(if_b.master));
    uart_frame_packer #(.WORD_W(32), .MSB_FIRST(0), .SYNC_LEN(0), .FRAME_WORDS(1), .CNT_W(2)) dut_c (
        .SYS_CLK(clk), .RST_N(rst_n), .bus(if_c.master));

    logic       m_tx_req, m_rd_req, m_frame_err, m_busy;
    logic [7:0] m_data_out;
    logic [2:0] m_state;
    assign m_tx_req    = if_a.tx_req | if_b.tx_req | if_c.tx_req;
    assign m_rd_req    = if_a.rd_req | if_b.rd_req | if_c.rd_req;
    assign m_frame_err = if_a.frame_err | if_b.frame_err | if_c.frame_err;
    assign m_busy      = (sel == 0) ? if_a.busy : (sel == 1) ? if_b.busy : if_c.busy;
    assign m_data_out  = (sel == 0) ? if_a.data_out : (sel == 1) ? if_b.data_out : if_c.data_out;
    assign m_state     = (sel == 0) ? if_a.dbg_state : (sel == 1) ? if_b.dbg_state : if_c.dbg_state;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: the word read by a strobe appears on data_in one cycle later; junk meanwhile.
    initial begin : fifo_model
        logic [63:0] nxt;
        bit          pend;
        pend = 1'b0;
        nxt  = '0;
        forever begin
            @(posedge clk); #1;
            if (pend) begin
                data_in = nxt;
                pend    = 1'b0;
            end
            if (m_rd_req) begin
                rd_cnt++;
                check("rd_req_while_empty", (fifo_q.size() != 0), 1);
                nxt     = (fifo_q.size() != 0) ? fifo_q.pop_front() : 64'd0;
                pend    = 1'b1;
                data_in = {$urandom, $urandom};
            end
            rd_empty = (fifo_q.size() == 0);
        end
    end

    // Transmitter model and scoreboard: every request is matched against the expected byte queue.
    initial begin : tx_model
        logic [7:0] b;
        forever begin
            @(posedge clk); #1;
            if (tx_auto && m_tx_req) begin
                b = m_data_out;
                tx_cnt++;
                check("tx_byte_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("tx_byte", b, exp_q.pop_front());
                for (int i = 0; i < tx_lat; i++) begin
                    @(posedge clk); #1;
                    check("tx_req_single", m_tx_req, 0);
                    check("data_hold_pre", m_data_out, b);
                end
                tx_busy = 1'b1;
                for (int i = 0; i < tx_len; i++) begin
                    @(posedge clk); #1;
                    check("data_hold_busy", m_data_out, b);
                end
                tx_busy = 1'b0;
            end
        end
    end

    initial begin : ferr_mon
        forever begin
            @(posedge clk); #1;
            if (m_frame_err) ferr_cnt++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic pulse_start();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit payload);
        exp_q.push_back(b);
        if (payload) csum_acc = csum_acc + b;
    endtask

    task automatic push_word16(input logic [15:0] w);
        push_byte(w[15:8], 1'b1);
        push_byte(w[7:0], 1'b1);
    endtask

    task automatic push_csum();
`ifdef FRAME_CSUM_EN
        exp_q.push_back(8'(9'd256 - {1'b0, csum_acc}));
`endif
        csum_acc = '0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_end_in_time"}, (n < budget), 1);
    endtask

    task automatic wait_tx(input string tag, input int target, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (!(tx_cnt == target && (st == 3'd7 || m_state == st)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reached"}, (n < budget), 1);
    endtask

    initial begin : main
        int rd0, tx0, f0, total;
        logic [15:0] w[12];

        repeat (3) @(negedge clk);
        check("rst_rd_req", m_rd_req, 0);
        check("rst_tx_req", m_tx_req, 0);
        check("rst_data_out", m_data_out, 0);
        check("rst_frame_err", m_frame_err, 0);
        check("rst_busy", m_busy, 0);
        check("rst_state", m_state, ST_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: start latency, then reset while SEND is active and the transmitter is busy
        sel = 0; tx_auto = 1'b0; tx_busy = 1'b1;
        pulse_start();
        check("t1_state_sync", m_state, ST_SYNC);
        check("t1_no_req_yet", m_tx_req, 0);
        @(negedge clk);
        check("t1_first_req", m_tx_req, 1);
        check("t1_first_byte", m_data_out, 8'hFF);
        check("t1_state_send", m_state, ST_SEND);
        #2 rst_n = 1'b0;
        #1;
        check("t1_tx_req", m_tx_req, 0);
        check("t1_data_out", m_data_out, 0);
        check("t1_busy", m_busy, 0);
        check("t1_rd_req", m_rd_req, 0);
        check("t1_frame_err", m_frame_err, 0);
        check("t1_state", m_state, ST_IDLE);
        tx_busy = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); tx_auto = 1'b1;

        // T2: two-word frame on the default layout
        fifo_q.push_back(64'h1234); fifo_q.push_back(64'hABCD);
        push_byte(8'hFF, 1'b0); push_byte(8'h00, 1'b0);
        push_byte(8'h12, 1'b1); push_byte(8'h34, 1'b1);
        push_byte(8'hAB, 1'b1); push_byte(8'hCD, 1'b1);
        push_csum();
        rd0 = rd_cnt; f0 = ferr_cnt; total = tx_cnt + exp_q.size();
        pulse_start();
        wait_end("t2", 2000);
        check("t2_tx_count_at_busy_fall", tx_cnt, total);
        check("t2_rd_pulses", rd_cnt - rd0, 2);
        check("t2_no_frame_err", ferr_cnt - f0, 0);
        check("t2_state_idle", m_state, ST_IDLE);

        // T4: FIFO runs dry after the first word; nothing may move until it refills
        fifo_q.push_back(64'h5A0F);
        push_byte(8'hFF, 1'b0); push_byte(8'h00, 1'b0);
        push_byte(8'h5A, 1'b1); push_byte(8'h0F, 1'b1);
        rd0 = rd_cnt; tx0 = tx_cnt;
        pulse_start();
        wait_tx("t4_stall", tx0 + 4, ST_FETCH, 500);
        tx0 = tx_cnt;
        f0  = rd_cnt;
        repeat (50) @(negedge clk);
        check("t4_stall_no_rd", rd_cnt, f0);
        check("t4_stall_no_tx", tx_cnt, tx0);
        check("t4_stall_state", m_state, ST_FETCH);
        check("t4_stall_busy", m_busy, 1);
        fifo_q.push_back(64'hC3E1);
        push_byte(8'hC3, 1'b1); push_byte(8'hE1, 1'b1);
        push_csum();
        wait_end("t4", 2000);
        check("t4_rd_pulses", rd_cnt - rd0, 2);

        // T6: slow transmitter acknowledge
        tx_lat = 10;
        fifo_q.push_back(64'h0102); fifo_q.push_back(64'h8081);
        push_byte(8'hFF, 1'b0); push_byte(8'h00, 1'b0);
        push_byte(8'h01, 1'b1); push_byte(8'h02, 1'b1);
        push_byte(8'h80, 1'b1); push_byte(8'h81, 1'b1);
        push_csum();
        total = tx_cnt + exp_q.size();
        pulse_start();
        wait_end("t6", 3000);
        check("t6_tx_count", tx_cnt, total);
        tx_lat = 1;

        // T3: 32-bit words, low byte first, no sync
        sel = 2;
        @(negedge clk);
        fifo_q.push_back(64'h1122_3344);
        push_byte(8'h44, 1'b1); push_byte(8'h33, 1'b1);
        push_byte(8'h22, 1'b1); push_byte(8'h11, 1'b1);
        push_csum();
        rd0 = rd_cnt; total = tx_cnt + exp_q.size();
        pulse_start();
        wait_end("t3", 2000);
        check("t3_tx_count", tx_cnt, total);
        check("t3_rd_pulses", rd_cnt - rd0, 1);

        // T5: restart during the second byte of word 3 of an 8-word frame
        sel = 1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            w[i] = 16'($urandom_range(0, 16'hFFFF));
            fifo_q.push_back({48'd0, w[i]});
        end
        push_byte(8'hFF, 1'b0); push_byte(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) push_word16(w[i]);
        push_csum();
        push_byte(8'hFF, 1'b0); push_byte(8'h00, 1'b0);
        for (int i = 4; i < 12; i++) push_word16(w[i]);
        push_csum();
        rd0 = rd_cnt; f0 = ferr_cnt; tx0 = tx_cnt; total = tx_cnt + exp_q.size();
        pulse_start();
        wait_tx("t5_word3_byte1", tx0 + 10, 3'd7, 1000);
        pulse_start();
        wait_end("t5", 4000);
        check("t5_frame_err_pulses", ferr_cnt - f0, 1);
        check("t5_rd_pulses", rd_cnt - rd0, 12);
        check("t5_tx_count", tx_cnt, total);
        check("t5_state_idle", m_state, ST_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
